// File: rtl/count_seq_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | count_seq_ctrl_pkg : shared state encoding and default counter width |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package count_seq_ctrl_pkg;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/count_seq_ctrl_cntr_core.sv
// +----------------------------------------------------------------------+
// | cntr_core : count register with sync clear and increment enable      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module cntr_core
  import count_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;

  // Sync clear wins over enable; the sum wraps naturally at WIDTH bits.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= r_q + c_one;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/count_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | count_seq_ctrl : start/stop/hold sequenced counter, one-shot or wrap |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module count_seq_ctrl
  import count_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             wrap,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_limit;
  logic             r_wrap;
  logic             w_capture;
  logic             w_clr;
  logic             w_en;
  logic             w_at_limit;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_limit <= '0;
      r_wrap  <= 1'b0;
    end else if (w_capture) begin
      r_limit <= limit;
      r_wrap  <= wrap;
    end
  end

  assign w_at_limit = (q == r_limit);

  // Clearing already on the start edge makes q read 0 throughout CLR.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_clr       = 1'b1;
          w_state_nxt = CLR;
        end
      end
      CLR: begin
        w_clr       = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (hold) begin
          w_state_nxt = RUN;
        end else if (w_at_limit) begin
          if (r_wrap) begin
            w_clr = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_en = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  cntr_core #(
    .WIDTH (WIDTH)
  ) u_cntr_core (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (w_clr),
    .en      (w_en),
    .q       (q)
  );

  assign busy = (r_state == CLR) || (r_state == RUN);
  assign tc   = (r_state == RUN) && w_at_limit;
  assign done = (r_state == DONE);

endmodule

`default_nettype wire

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port clear_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a count run; sampled only in IDLE.
REQ-005 SHALL have port stop  input  1  abort the run; returns to IDLE, count retained.
REQ-006 SHALL have port hold  input  1  pause counting in RUN.
REQ-007 SHALL have port wrap  input  1  mode: 1 = free-run modulo (limit+1), 0 = one-shot; sampled with start.
REQ-008 SHALL have port limit  input  WIDTH  terminal count value; sampled with start.
REQ-009 SHALL have port q  output  WIDTH  current count.
REQ-010 SHALL have port busy  output  1  high in CLR, RUN.
REQ-011 SHALL have port tc  output  1  terminal count: high while state==RUN and q==limit_r.
REQ-012 SHALL have port done  output  1  one-cycle pulse, high in DONE.

Function
REQ-013 SHALL implement FSM states IDLE, CLR, RUN, DONE.
REQ-014 IDLE: start=1 SHALL capture limit->limit_r, wrap->wrap_r and move to CLR; otherwise q holds.
REQ-015 CLR: SHALL load q=0 and move to RUN unconditionally on the next edge (stop ignored in CLR).
REQ-016 RUN, per edge, priority order: stop -> IDLE, q held; hold -> no change; q==limit_r -> terminal action; else q<=q+1.
REQ-017 Terminal action, wrap_r=0: q holds, state -> DONE; wrap_r=1: q<=0, stay in RUN.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE; q holds final value.
REQ-019 start outside IDLE SHALL be ignored; limit/wrap changes after capture SHALL have no effect.
REQ-020 limit=0: one-shot SHALL give CLR, one RUN cycle with tc=1, DONE; wrap SHALL hold q=0 with tc=1 every RUN cycle.
REQ-021 limit=2^WIDTH-1 SHALL count full range; no arithmetic overflow beyond WIDTH bits.
REQ-022 Latency: start sampled at edge k -> q=0 after k, RUN after k+1, q==L after k+1+L unpaused edges; done high after edge k+2+L (one-shot).
REQ-023 tc, busy, done SHALL decode only registered state/count (no input-to-output path).

Reset
REQ-024 clear_n=0 SHALL immediately force state=IDLE, q=0, limit_r=0, wrap_r=0; busy=tc=done=0.
REQ-025 Reset mid-run SHALL abort without a done pulse; release SHALL occur synchronously-safe, first action on the first edge after deassertion.

Structure
REQ-026 Shared package SHALL hold the state enum (IDLE, CLR, RUN, DONE) and default width constant CNT_WIDTH=4.
REQ-027 Count register SHALL live in sub-module cntr_core (sync clear, enable, increment, async reset clear_n); FSM in count_seq_ctrl.

Verification
REQ-028 Reset: clear_n=0 during RUN at q=5 -> q=0, busy=0, done never pulses.
REQ-029 One-shot limit=3, wrap=0: start 1 cycle -> q 0,1,2,3, tc=1 at q=3, done pulse one cycle later, then IDLE with q=3.
REQ-030 Wrap limit=2: -> q 0,1,2,0,1,2...; tc high each q=2 cycle; done stays 0; stop -> IDLE with q retained.
REQ-031 hold=1 for 4 cycles at q=4 (limit=9) -> q stays 4, then resumes 5; hold+stop together -> IDLE.
REQ-032 start asserted in RUN with new limit=1 -> ignored; run completes at original limit.
REQ-033 limit=0 one-shot -> tc=1 one cycle, done next; limit=15 -> counts 0..15 then done.
